// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Rev 1.0
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam logic EVEN             = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // High when data plus received parity bit disagree with the configured sense.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic                 par_bit);
    return (^data) ^ par_bit ^ EVEN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: byte handshake and status bundle between receiver and consumer.
// Rev 1.0
`default_nettype none

interface uart_receiver_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data_out,
    output rx_valid,
    output frame_err,
    output parity_err,
    output overrun,
    output busy,
    input  rx_ack
  );

  modport slave (
    input  data_out,
    input  rx_valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    input  busy,
    output rx_ack
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer (reset to 1, idle-high line) with falling-edge flag.
// Rev 1.0
`default_nettype none

module uart_rx_sync (
  input  wire  clk,
  input  wire  rstn,
  input  wire  async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receiver with valid/ack output and error flags.
// Rev 1.0 -- define UART_RX_PARITY_EN for 8E1 frames with parity checking.
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  wire             clk,
  input  wire             rstn,
  input  wire             serial_in,
  input  wire             s_tick,
  uart_receiver_if.master rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (serial_in),
    .sync_out (rx_s),
    .fall     (rx_fall)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 par_bad;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    // Consumer ack; a load in STOP below overrides rx_valid in the same cycle.
    if (rx.rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (rx_fall) state_d = START;
      end

      START: begin
        if (s_tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            par_bad_d  = parity_bad(shift_q, rx_s);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (s_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (!rx_s) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
            par_bad_d    = 1'b0;
`endif
            if (rx_s && !par_bad) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              if (valid_q && !rx.rx_ack) overrun_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rx.parity_err = parity_err_q;
`else
  assign rx.parity_err = 1'b0;
`endif

  assign rx.data_out  = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.overrun   = overrun_q;
  assign rx.frame_err = frame_err_q;
  assign rx.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scenario tasks driving serial frames against a byte scoreboard.
// Rev 1.0
`default_nettype none

module tb_uart_receiver;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic serial_in = 1'b1;
  logic s_tick = 1'b1;

  uart_receiver_if rx_if ();

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .s_tick    (s_tick),
    .rx        (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records each rx_valid rise and counts error-pulse activity.
  logic [7:0] got_mem [0:63];
  int         got_cyc [0:63];
  int         got_n = 0;
  logic       valid_prev = 1'b0, fe_prev = 1'b0, pe_prev = 1'b0;
  int         fe_hi = 0, fe_long = 0, pe_hi = 0, pe_long = 0, busy_hi = 0;

  always @(negedge clk) begin
    if (rx_if.rx_valid && !valid_prev && got_n < 64) begin
      got_mem[got_n] = rx_if.data_out;
      got_cyc[got_n] = cyc;
      got_n++;
    end
    if (rx_if.frame_err) fe_hi++;
    if (rx_if.frame_err && fe_prev) fe_long++;
    if (rx_if.parity_err) pe_hi++;
    if (rx_if.parity_err && pe_prev) pe_long++;
    if (rx_if.busy) busy_hi++;
    valid_prev = rx_if.rx_valid;
    fe_prev    = rx_if.frame_err;
    pe_prev    = rx_if.parity_err;
  end

  logic [7:0] exp_q [$];
  int total = 0;
  int pass  = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    tick(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_v);
  endtask

  task automatic ack_once();
    rx_if.rx_ack = 1'b1;
    tick(1);
    rx_if.rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    serial_in = 1'b1;
    rx_if.rx_ack = 1'b0;
    tick(3);
    total++; if (rx_if.data_out !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_if.data_out); else pass++;
    total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); else pass++;
    total++; if (rx_if.frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", rx_if.frame_err); else pass++;
    total++; if (rx_if.parity_err !== 1'b0) $display("FAIL reset_parity_err got=%b exp=0", rx_if.parity_err); else pass++;
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", rx_if.overrun); else pass++;
    total++; if (rx_if.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", rx_if.busy); else pass++;
    rstn = 1'b1;
    tick(5);
  endtask

  task automatic test_ideal();
    int g0, fe0, pe0, c0;
    logic [7:0] e;
    g0 = got_n; fe0 = fe_hi; pe0 = pe_hi; c0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(20);
    e = exp_q.pop_front();
    total++; if (got_mem[g0] !== e) $display("FAIL ideal_data got=%h exp=%h", got_mem[g0], e); else pass++;
    total++; if (got_cyc[g0] - c0 != LAT) $display("FAIL ideal_latency got=%0d exp=%0d", got_cyc[g0] - c0, LAT); else pass++;
    total++; if (fe_hi != fe0 || pe_hi != pe0) $display("FAIL ideal_flags got fe=%0d pe=%0d exp 0", fe_hi - fe0, pe_hi - pe0); else pass++;
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL ideal_overrun got=%b exp=0", rx_if.overrun); else pass++;
    ack_once();
    total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL ideal_ack_clear got=%b exp=0", rx_if.rx_valid); else pass++;
  endtask

  task automatic test_glitch();
    int g0, fe0, b0;
    g0 = got_n; fe0 = fe_hi; b0 = busy_hi;
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    tick(30);
    total++; if (busy_hi == b0) $display("FAIL glitch_busy_pulse got=0 cycles exp>0"); else pass++;
    total++; if (rx_if.busy !== 1'b0) $display("FAIL glitch_busy_idle got=%b exp=0", rx_if.busy); else pass++;
    total++; if (got_n != g0 || rx_if.rx_valid !== 1'b0) $display("FAIL glitch_no_data got=%0d exp=0", got_n - g0); else pass++;
    total++; if (fe_hi != fe0) $display("FAIL glitch_no_flags got=%0d exp=0", fe_hi - fe0); else pass++;
  endtask

  task automatic test_frame_err();
    int g0, fe0, fl0;
    logic [7:0] e;
    g0 = got_n; fe0 = fe_hi; fl0 = fe_long;
    send_frame(8'h3C, 1'b0);
    tick(48);
    total++; if (fe_hi - fe0 != 1) $display("FAIL ferr_pulse_count got=%0d exp=1", fe_hi - fe0); else pass++;
    total++; if (fe_long != fl0) $display("FAIL ferr_pulse_width got=%0d wide exp=0", fe_long - fl0); else pass++;
    total++; if (got_n != g0 || rx_if.rx_valid !== 1'b0) $display("FAIL ferr_no_data got=%0d exp=0", got_n - g0); else pass++;
    total++; if (rx_if.busy !== 1'b0) $display("FAIL ferr_stuck_low_busy got=%b exp=0", rx_if.busy); else pass++;
    serial_in = 1'b1;
    tick(32);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(20);
    e = exp_q.pop_front();
    total++; if (got_n != g0 + 1 || got_mem[g0] !== e) $display("FAIL ferr_recover got=%h exp=%h", got_mem[g0], e); else pass++;
    ack_once();
  endtask

  task automatic test_overrun();
    int g0;
    logic [7:0] e;
    g0 = got_n;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(20);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    tick(20);
    e = exp_q.pop_front();
    total++; if (got_mem[g0] !== e) $display("FAIL ovr_first got=%h exp=%h", got_mem[g0], e); else pass++;
    e = exp_q.pop_front();
    total++; if (rx_if.data_out !== e) $display("FAIL ovr_data got=%h exp=%h", rx_if.data_out, e); else pass++;
    total++; if (rx_if.rx_valid !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", rx_if.rx_valid); else pass++;
    total++; if (rx_if.overrun !== 1'b1) $display("FAIL ovr_flag got=%b exp=1", rx_if.overrun); else pass++;
    ack_once();
    total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL ovr_ack_valid got=%b exp=0", rx_if.rx_valid); else pass++;
    total++; if (rx_if.overrun !== 1'b0) $display("FAIL ovr_ack_overrun got=%b exp=0", rx_if.overrun); else pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int g0, pe0, pl0;
    logic [7:0] d, e;
    d = 8'h07;
    g0 = got_n; pe0 = pe_hi; pl0 = pe_long;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    tick(20);
    total++; if (pe_hi - pe0 != 1 || pe_long != pl0) $display("FAIL par_pulse got=%0d wide=%0d exp=1/0", pe_hi - pe0, pe_long - pl0); else pass++;
    total++; if (got_n != g0 || rx_if.rx_valid !== 1'b0) $display("FAIL par_no_data got=%0d exp=0", got_n - g0); else pass++;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    tick(20);
    e = exp_q.pop_front();
    total++; if (got_mem[g0] !== e || rx_if.rx_valid !== 1'b1) $display("FAIL par_good got=%h exp=%h", got_mem[g0], e); else pass++;
    ack_once();
  endtask
`endif

  task automatic test_reset_mid();
    int g0;
    logic [7:0] d, e;
    g0 = got_n;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    tick(20);
    e = exp_q.pop_front();
    total++; if (got_mem[g0] !== e) $display("FAIL rmid_pre_data got=%h exp=%h", got_mem[g0], e); else pass++;
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    serial_in = d[4];
    tick(OS / 2);
    total++; if (rx_if.busy !== 1'b1) $display("FAIL rmid_busy_before got=%b exp=1", rx_if.busy); else pass++;
    rstn = 1'b0;
    #2;
    total++; if (rx_if.busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", rx_if.busy); else pass++;
    total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", rx_if.rx_valid); else pass++;
    total++; if (rx_if.data_out !== 8'h00) $display("FAIL rmid_data got=%h exp=00", rx_if.data_out); else pass++;
    serial_in = 1'b1;
    tick(3);
    rstn = 1'b1;
    tick(20);
    g0 = got_n;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(20);
    e = exp_q.pop_front();
    total++; if (got_n != g0 + 1 || got_mem[g0] !== e) $display("FAIL rmid_next got=%h exp=%h", got_mem[g0], e); else pass++;
    total++; if (rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) $display("FAIL rmid_flags got fe=%b ovr=%b exp 0", rx_if.frame_err, rx_if.overrun); else pass++;
  endtask

  initial begin
    rx_if.rx_ack = 1'b0;
    test_reset();
    test_ideal();
    test_glitch();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage that sits directly downstream of the UART transmitter (and its data error injector path). It consumes the 1-bit serial line and recovers 8-bit frames (1 start, 8 data LSB-first, optional parity, 1 stop) using a baud tick at OVERSAMPLE× the bit rate. It presents each byte on a valid/ack handshake and flags framing, parity and overrun errors.

## Interface
- OVERSAMPLE, 16: ticks per bit period; even, ≥ 4.
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- serial_in  in  1  UART line, idle high; asynchronous to clk.
- s_tick  in  1  one-clk pulse at OVERSAMPLE × bit rate.
- rx_ack  in  1  consumer has taken data_out; clears rx_valid.
- data_out  out  8  last good received byte.
- rx_valid  out  1  data_out holds an unread byte.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- parity_err  out  1  one-clk pulse: parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined.
- overrun  out  1  sticky: a good frame completed while rx_valid was 1; cleared by rx_ack.
- busy  out  1  high in any state other than IDLE.

One clock; reset is asynchronous and active-low (clk, rstn).

## Operation
- serial_in passes a 2-flop synchronizer (both flops reset to 1); rx_s is the second-flop output. A falling edge is rx_s = 0 with the previous rx_s = 1.
- States: IDLE, START, DATA, PARITY (only if UART_RX_PARITY_EN), STOP.
- IDLE: tick_cnt = 0, bit_cnt = 0. A falling edge on rx_s → START.
- START: count s_tick. At tick OVERSAMPLE/2 (mid start bit), sample rx_s. If 0 → DATA and clear tick_cnt. If 1 → glitch: IDLE, no flags.
- DATA: every OVERSAMPLE ticks, sample rx_s into shift_reg[7]; shift right (LSB first). After 8 samples, go to PARITY if enabled, else STOP.
- PARITY: after OVERSAMPLE ticks, sample the parity bit; par_bad = (^shift_reg) ^ sample ^ EVEN (even parity) → STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - If 1 and no parity error: load data_out; set rx_valid. If rx_valid was already 1 and rx_ack is not asserted that cycle, also set overrun; data_out is overwritten with the newer byte.
  - If 0: pulse frame_err; data_out and rx_valid unchanged.
  - Parity error: pulse parity_err; data_out unchanged.
  - In every case → IDLE.
- Frame-error recovery: IDLE re-arms only on a genuine 1→0 edge, so a stuck-low line produces no further frames.
- rx_ack with rx_valid = 1 clears rx_valid and overrun on the next edge. rx_ack with rx_valid = 0 is ignored. A simultaneous load and ack gives rx_valid = 1 and no overrun.
- tick_cnt width is $clog2(OVERSAMPLE); bit_cnt is 4 bits. Counters advance only on s_tick.

## Timing
- Reset values: data_out = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0; state = IDLE.
- rstn asserted mid-frame aborts the frame immediately: no flags, no data.
- Input latency: 2 clk from serial_in to rx_s.
- Sample points after start detection:
  - Start bit: tick OVERSAMPLE/2.
  - Data bit k (k = 0..7): tick OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - Stop bit: tick OVERSAMPLE/2 + 9·OVERSAMPLE = 152 for OVERSAMPLE = 16 (168 with parity).
- rx_valid, frame_err and parity_err appear 1 clk after the stop-sample tick.
- Error pulses are exactly one clk wide.
- busy rises 1 clk after the falling edge is detected and falls with the return to IDLE.
- With s_tick held at 1 (one tick per clk), operation is identical with ticks counted as cycles.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present, 11-bit frames, even parity checked, parity_err driven.
- Not defined: PARITY state and logic absent, 10-bit frames, parity_err tied to 0.

## Structure
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP)
  - DATA_BITS = 8
  - default OVERSAMPLE = 16
  - parity sense EVEN = 1'b0
- Sub-module uart_rx_sync: 2-flop synchronizer with reset-to-1 and falling-edge output; reusable elsewhere in the design.

## Test plan
- Ideal frame 0xA5, OVERSAMPLE = 16, s_tick every clk, no parity → data_out = 0xA5; rx_valid rises 155 clk after the serial_in fall (2 sync + 1 detect + 152 ticks); no flags.
- Glitch low pulse of 4 ticks on an idle line → START then back to IDLE; busy pulses; rx_valid stays 0; no flags.
- Frame 0x3C with stop bit forced 0 → frame_err pulses for 1 clk; rx_valid stays 0; no frame is received until the line returns high and falls again.
- Two frames 0x11 then 0x22 with no rx_ack → data_out = 0x22, rx_valid = 1, overrun = 1; rx_ack clears both on the next clk.
- Under UART_RX_PARITY_EN: 0x07 sent with parity bit 0 (odd count, so wrong) → parity_err pulses and rx_valid stays 0. Then 0x07 with parity bit 1 → data_out = 0x07, rx_valid = 1.
- rstn pulled low mid DATA bit 4 → all outputs reset, busy = 0. The next clean frame 0x5A is received correctly.
